// File: rtl/eth_tx_arb.sv
// eth_tx_arb: packet-granular round-robin arbiter sharing one 64-bit AXI-Stream
// TX path toward the Ethernet MAC between N_REQ producers.
//   eth_clk, eth_rst_n          : clock, async active-low reset
//   s_tvalid/s_tready/s_tlast   : per-requester handshake and end of frame
//   s_tkeep/s_tdata             : per-requester byte enables / data, lane i at [8i+:8] / [64i+:64]
//   m_tvalid/m_tready/m_tlast   : master handshake and end of frame toward the MAC
//   m_tkeep/m_tdata/m_tuser     : master byte enables / data / bad-frame marker
//   grant                       : one-hot current owner, zero when no owner
//   abort_cnt                   : saturating count of watchdog aborts
module eth_tx_arb #(
   parameter int unsigned N_REQ       = 3,
   parameter int unsigned GAP_CYC     = 1,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic                eth_clk,
   input  logic                eth_rst_n,
   input  logic [N_REQ-1:0]    s_tvalid,
   output logic [N_REQ-1:0]    s_tready,
   input  logic [N_REQ-1:0]    s_tlast,
   input  logic [N_REQ*8-1:0]  s_tkeep,
   input  logic [N_REQ*64-1:0] s_tdata,
   output logic                m_tvalid,
   input  logic                m_tready,
   output logic                m_tlast,
   output logic [7:0]          m_tkeep,
   output logic [63:0]         m_tdata,
   output logic                m_tuser,
   output logic [N_REQ-1:0]    grant,
   output logic [15:0]         abort_cnt
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned GAP_W = 4;
   localparam int unsigned WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PASS  = 2'd1,
      ST_ABORT = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [N_REQ-1:0]     grant_q, grant_d;
   logic [IDX_W-1:0]     gidx_q, gidx_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
   logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
   logic                 started_q, started_d;
   logic [15:0]          abort_cnt_q, abort_cnt_d;

   logic                 g_valid, g_last;
   logic [7:0]           g_keep;
   logic [63:0]          g_data;
   logic                 arb_hit;
   logic [IDX_W-1:0]     arb_idx;
   int unsigned          cand;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
      return (i == IDX_W'(N_REQ - 1)) ? '0 : i + IDX_W'(1);
   endfunction

   // Select the granted requester's stream.
   always_comb begin : granted_mux
      g_valid = 1'b0;
      g_last  = 1'b0;
      g_keep  = '0;
      g_data  = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (gidx_q == IDX_W'(i)) begin
            g_valid = s_tvalid[i];
            g_last  = s_tlast[i];
            g_keep  = s_tkeep[i*8 +: 8];
            g_data  = s_tdata[i*64 +: 64];
         end
      end
   end

   // First valid requester at or after rr_ptr, wrapping.
   always_comb begin : rr_search
      arb_hit = 1'b0;
      arb_idx = '0;
      cand    = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = 32'(rr_ptr_q) + k;
         if (cand >= N_REQ) cand = cand - N_REQ;
         if (!arb_hit && s_tvalid[IDX_W'(cand)]) begin
            arb_hit = 1'b1;
            arb_idx = IDX_W'(cand);
         end
      end
   end

   // State register.
   always_ff @(posedge eth_clk or negedge eth_rst_n) begin
      if (!eth_rst_n) begin
         state_q     <= ST_IDLE;
         grant_q     <= '0;
         gidx_q      <= '0;
         rr_ptr_q    <= '0;
         gap_cnt_q   <= '0;
         wd_cnt_q    <= '0;
         started_q   <= 1'b0;
         abort_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         gidx_q      <= gidx_d;
         rr_ptr_q    <= rr_ptr_d;
         gap_cnt_q   <= gap_cnt_d;
         wd_cnt_q    <= wd_cnt_d;
         started_q   <= started_d;
         abort_cnt_q <= abort_cnt_d;
      end
   end

   // Next-state logic.
   always_comb begin : next_state
      state_d     = state_q;
      grant_d     = grant_q;
      gidx_d      = gidx_q;
      rr_ptr_d    = rr_ptr_q;
      gap_cnt_d   = gap_cnt_q;
      wd_cnt_d    = wd_cnt_q;
      started_d   = started_q;
      abort_cnt_d = abort_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_hit) begin
               state_d   = ST_PASS;
               grant_d   = N_REQ'(1) << arb_idx;
               gidx_d    = arb_idx;
               wd_cnt_d  = '0;
               started_d = 1'b0;
            end
         end
         ST_PASS: begin
            if (g_valid && m_tready) begin
               wd_cnt_d  = '0;
               started_d = 1'b1;
               if (g_last) begin
                  rr_ptr_d  = next_idx(gidx_q);
                  grant_d   = '0;
                  gap_cnt_d = '0;
                  state_d   = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
               end
            end else if (TIMEOUT_CYC != 0 && started_q && !g_valid) begin
               // Only source starvation after the first beat counts toward the timeout.
               if (32'(wd_cnt_q) + 32'd1 >= TIMEOUT_CYC) begin
                  wd_cnt_d = '0;
                  state_d  = ST_ABORT;
               end else begin
                  wd_cnt_d = wd_cnt_q + WD_W'(1);
               end
            end
         end
         ST_ABORT: begin
            if (m_tready) begin
               if (abort_cnt_q != 16'hFFFF) abort_cnt_d = abort_cnt_q + 16'd1;
               rr_ptr_d  = next_idx(gidx_q);
               grant_d   = '0;
               gap_cnt_d = '0;
               state_d   = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
               gap_cnt_d = '0;
               state_d   = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode: pass-through in PASS, poisoned terminator in ABORT.
   always_comb begin : out_decode
      m_tvalid = 1'b0;
      m_tlast  = 1'b0;
      m_tuser  = 1'b0;
      m_tkeep  = '0;
      m_tdata  = '0;
      s_tready = '0;
      case (state_q)
         ST_PASS: begin
            m_tvalid = g_valid;
            m_tlast  = g_last;
            m_tkeep  = g_keep;
            m_tdata  = g_data;
            s_tready = grant_q & {N_REQ{m_tready}};
         end
         ST_ABORT: begin
            m_tvalid = 1'b1;
            m_tlast  = 1'b1;
            m_tuser  = 1'b1;
         end
         default: ;
      endcase
   end

   assign grant     = grant_q;
   assign abort_cnt = abort_cnt_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// tb_eth_tx_arb: scoreboard bench for eth_tx_arb. Source queues feed the requesters,
// a round-robin frame-order model fills the scoreboard, a monitor pops and compares.
module tb_eth_tx_arb;

   localparam int unsigned N_REQ       = 3;
   localparam int unsigned GAP_CYC     = 1;
   localparam int unsigned TIMEOUT_CYC = 8;
   localparam int          NR          = N_REQ;

   logic                eth_clk;
   logic                eth_rst_n;
   logic [N_REQ-1:0]    s_tvalid, s_tready, s_tlast;
   logic [N_REQ*8-1:0]  s_tkeep;
   logic [N_REQ*64-1:0] s_tdata;
   logic                m_tvalid, m_tready, m_tlast, m_tuser;
   logic [7:0]          m_tkeep;
   logic [63:0]         m_tdata;
   logic [N_REQ-1:0]    grant;
   logic [15:0]         abort_cnt;

   eth_tx_arb #(.N_REQ(N_REQ), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .eth_clk   (eth_clk),
      .eth_rst_n (eth_rst_n),
      .s_tvalid  (s_tvalid),
      .s_tready  (s_tready),
      .s_tlast   (s_tlast),
      .s_tkeep   (s_tkeep),
      .s_tdata   (s_tdata),
      .m_tvalid  (m_tvalid),
      .m_tready  (m_tready),
      .m_tlast   (m_tlast),
      .m_tkeep   (m_tkeep),
      .m_tdata   (m_tdata),
      .m_tuser   (m_tuser),
      .grant     (grant),
      .abort_cnt (abort_cnt)
   );

   initial eth_clk = 1'b0;
   always #5 eth_clk = ~eth_clk;

   typedef struct { logic [63:0] data; logic [7:0] keep; logic last; logic user; } beat_t;
   typedef struct { logic vld; logic [63:0] data; logic [7:0] keep; logic last; } item_t;

   beat_t sb_q[$];
   item_t src_q[NR][$];
   beat_t exp_src[NR][$];

   int checks = 0;
   int failures = 0;
   int model_ptr = 0;
   int model_aborts = 0;
   int rdy_mode = 0;
   int cyc = 0;

   logic [N_REQ-1:0] drv_hs, drv_bub;

   // monitor bookkeeping
   bit   prev_stall = 0;
   logic [74:0] prev_pl;
   int   last_hs_cyc = 0;
   bit   prev_last = 1;
   bit   measure_gap = 0;
   bit   gap_armed = 0;
   int   gap_min = 1000;
   int   gap_max = 0;
   int   abort_delta = -1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add_frame(input int r, input int len, input int max_bub);
      item_t it;
      item_t bub;
      beat_t bt;
      int nb;
      bub.vld = 1'b0; bub.data = '0; bub.keep = '0; bub.last = 1'b0;
      for (int b = 0; b < len; b++) begin
         it.vld  = 1'b1;
         it.data = {$urandom(), $urandom()};
         it.keep = 8'($urandom());
         it.last = (b == len - 1);
         src_q[r].push_back(it);
         bt.data = it.data; bt.keep = it.keep; bt.last = it.last; bt.user = 1'b0;
         exp_src[r].push_back(bt);
         if (b < len - 1 && max_bub > 0) begin
            nb = int'($urandom_range(0, max_bub));
            repeat (nb) src_q[r].push_back(bub);
         end
      end
   endtask

   // Two beats, then the source goes silent long enough to trip the watchdog.
   task automatic add_abort_frame(input int r);
      item_t it;
      beat_t bt;
      for (int b = 0; b < 2; b++) begin
         it.vld = 1'b1; it.data = {$urandom(), $urandom()}; it.keep = 8'($urandom()); it.last = 1'b0;
         src_q[r].push_back(it);
         bt.data = it.data; bt.keep = it.keep; bt.last = 1'b0; bt.user = 1'b0;
         exp_src[r].push_back(bt);
      end
      it.vld = 1'b0; it.data = '0; it.keep = '0; it.last = 1'b0;
      repeat (TIMEOUT_CYC + 4) src_q[r].push_back(it);
      bt.data = '0; bt.keep = '0; bt.last = 1'b1; bt.user = 1'b1;
      exp_src[r].push_back(bt);
   endtask

   // Reference order: every loaded frame is pending, owner rotates from the pointer.
   task automatic schedule();
      int r;
      bit done;
      beat_t bt;
      while (1) begin
         r = -1;
         for (int k = 0; k < NR; k++)
            if (r < 0 && exp_src[(model_ptr + k) % NR].size() > 0) r = (model_ptr + k) % NR;
         if (r < 0) break;
         done = 0;
         while (!done) begin
            bt = exp_src[r].pop_front();
            sb_q.push_back(bt);
            done = bt.last;
            if (bt.user) model_aborts++;
         end
         model_ptr = (r + 1) % NR;
      end
   endtask

   function automatic bit sources_busy();
      bit busy = 0;
      for (int r = 0; r < NR; r++) if (src_q[r].size() > 0) busy = 1;
      return busy;
   endfunction

   task automatic drain(input string name, input int budget);
      int n = 0;
      while ((sb_q.size() > 0 || sources_busy()) && n < budget) begin
         @(negedge eth_clk);
         n++;
      end
      check({name, "_drain_remaining"}, 128'(sb_q.size()), 128'(0));
      repeat (4) @(negedge eth_clk);
   endtask

   // Source and MAC-ready driver.
   initial begin : src_drv
      s_tvalid = '0; s_tlast = '0; s_tkeep = '0; s_tdata = '0; m_tready = 1'b0;
      forever begin
         @(negedge eth_clk);
         drv_hs = s_tvalid & s_tready;
         for (int r = 0; r < NR; r++) drv_bub[r] = (src_q[r].size() > 0) && !src_q[r][0].vld;
         @(posedge eth_clk);
         #1;
         for (int r = 0; r < NR; r++) begin
            if (src_q[r].size() > 0 && (drv_bub[r] || drv_hs[r])) void'(src_q[r].pop_front());
            if (src_q[r].size() > 0 && src_q[r][0].vld) begin
               s_tvalid[r]         = 1'b1;
               s_tlast[r]          = src_q[r][0].last;
               s_tkeep[r*8 +: 8]   = src_q[r][0].keep;
               s_tdata[r*64 +: 64] = src_q[r][0].data;
            end else begin
               s_tvalid[r]         = 1'b0;
               s_tlast[r]          = 1'b0;
               s_tkeep[r*8 +: 8]   = '0;
               s_tdata[r*64 +: 64] = '0;
            end
         end
         case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = !m_tready;
            default: m_tready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: protocol invariants plus scoreboard compare on every master beat.
   initial begin : mon
      beat_t e;
      int idle;
      forever begin
         @(negedge eth_clk);
         cyc++;
         if (!eth_rst_n) begin
            prev_stall = 0;
            continue;
         end
         check("grant_onehot0", 128'($onehot0(grant)), 128'(1));
         check("tready_not_granted", 128'(s_tready & ~grant), 128'(0));
         check("valid_without_owner", 128'(m_tvalid && (grant == '0)), 128'(0));
         if (prev_stall)
            check("stall_hold", 128'({m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser}), 128'(prev_pl));
         if (m_tvalid && m_tready) begin
            if (sb_q.size() == 0) begin
               check("unexpected_beat", 128'({m_tdata, m_tkeep, m_tlast, m_tuser}), 128'(0));
            end else begin
               e = sb_q.pop_front();
               check("beat", 128'({m_tdata, m_tkeep, m_tlast, m_tuser}),
                     128'({e.data, e.keep, e.last, e.user}));
            end
            if (prev_last && gap_armed) begin
               idle = cyc - last_hs_cyc - 1;
               if (idle < gap_min) gap_min = idle;
               if (idle > gap_max) gap_max = idle;
            end
            if (m_tuser) abort_delta = cyc - last_hs_cyc;
            if (m_tlast && measure_gap) gap_armed = 1;
            last_hs_cyc = cyc;
            prev_last   = m_tlast;
         end
         prev_stall = m_tvalid && !m_tready;
         prev_pl    = {1'b1, m_tdata, m_tkeep, m_tlast, m_tuser};
      end
   end

   initial begin : safety
      #900000;
      $display("FAIL global_timeout reached without finishing");
      $fatal(1);
   end

   initial begin : main
      item_t it;
      beat_t bt;
      logic [63:0] d3;
      bit found;
      int nf;

      eth_rst_n = 1'b0;
      repeat (2) @(negedge eth_clk);
      check("rst_m_tvalid", 128'(m_tvalid), 128'(0));
      check("rst_grant", 128'(grant), 128'(0));
      check("rst_s_tready", 128'(s_tready), 128'(0));
      check("rst_abort_cnt", 128'(abort_cnt), 128'(0));
      check("rst_m_payload", 128'({m_tdata, m_tkeep, m_tlast, m_tuser}), 128'(0));
      eth_rst_n = 1'b1;
      repeat (2) @(negedge eth_clk);

      // single 5-beat frame from requester 0, grant one cycle after valid
      rdy_mode = 0;
      add_frame(0, 5, 0);
      schedule();
      found = 0;
      for (int n = 0; n < 20 && !found; n++) begin
         @(negedge eth_clk);
         if (s_tvalid[0]) found = 1;
      end
      check("req0_valid_seen", 128'(found), 128'(1));
      check("grant_before_arb", 128'(grant), 128'(0));
      @(negedge eth_clk);
      check("grant_after_arb", 128'(grant), 128'(3'b001));
      drain("single", 100);

      // pointer moved to 1: requester 1 must beat requester 0
      add_frame(0, 2, 0);
      add_frame(1, 3, 0);
      schedule();
      drain("ptr_after_r0", 100);
      add_frame(2, 1, 0);
      schedule();
      drain("r2_single", 100);

      // all requesters continuously pending, two 2-beat frames each
      measure_gap = 1; gap_armed = 0; gap_min = 1000; gap_max = 0;
      for (int rep = 0; rep < 2; rep++)
         for (int r = 0; r < NR; r++) add_frame(r, 2, 0);
      schedule();
      drain("rotation", 200);
      measure_gap = 0; gap_armed = 0;
      check("gap_min", 128'(gap_min), 128'(GAP_CYC + 1));
      check("gap_max", 128'(gap_max), 128'(GAP_CYC + 1));

      // MAC backpressure 1010 during a 4-beat frame
      rdy_mode = 1;
      add_frame(2, 4, 0);
      schedule();
      drain("toggle_ready", 100);
      rdy_mode = 0;
      check("no_abort_on_backpressure", 128'(abort_cnt), 128'(model_aborts));

      // source starvation after two beats, requester 2 pending
      add_abort_frame(1);
      add_frame(2, 2, 0);
      schedule();
      drain("watchdog", 200);
      check("abort_cnt_one", 128'(abort_cnt), 128'(1));
      check("abort_cnt_model", 128'(abort_cnt), 128'(model_aborts));
      check("abort_latency", 128'(abort_delta), 128'(TIMEOUT_CYC + 1));

      // randomized traffic with random backpressure and short mid-frame bubbles
      rdy_mode = 2;
      for (int round = 0; round < 8; round++) begin
         for (int r = 0; r < NR; r++) begin
            nf = int'($urandom_range(0, 3));
            repeat (nf) add_frame(r, int'($urandom_range(1, 6)), 3);
         end
         schedule();
         drain("random", 1000);
      end
      rdy_mode = 0;
      check("random_abort_cnt", 128'(abort_cnt), 128'(model_aborts));

      // reset in the middle of a 6-beat frame from requester 1, pointer at 1 beforehand
      add_frame(0, 1, 0);
      schedule();
      drain("pre_reset", 100);
      d3 = '0;
      for (int b = 0; b < 6; b++) begin
         it.vld = 1'b1; it.data = {$urandom(), $urandom()}; it.keep = 8'($urandom()); it.last = (b == 5);
         src_q[1].push_back(it);
         if (b < 2) begin
            bt.data = it.data; bt.keep = it.keep; bt.last = 1'b0; bt.user = 1'b0;
            sb_q.push_back(bt);
         end
         if (b == 2) d3 = it.data;
      end
      found = 0;
      for (int n = 0; n < 60 && !found; n++) begin
         @(posedge eth_clk);
         #2;
         if (m_tvalid && m_tdata == d3) found = 1;
      end
      check("reached_beat3", 128'(found), 128'(1));
      check("beats_before_reset", 128'(sb_q.size()), 128'(0));
      eth_rst_n = 1'b0;
      #1;
      check("async_rst_m_tvalid", 128'(m_tvalid), 128'(0));
      check("async_rst_grant", 128'(grant), 128'(0));
      check("async_rst_s_tready", 128'(s_tready), 128'(0));
      for (int r = 0; r < NR; r++) begin
         src_q[r].delete();
         exp_src[r].delete();
      end
      sb_q.delete();
      s_tvalid = '0; s_tlast = '0; s_tkeep = '0; s_tdata = '0;
      model_ptr = 0;
      model_aborts = 0;
      repeat (3) @(negedge eth_clk);
      check("rst_clears_abort_cnt", 128'(abort_cnt), 128'(0));
      eth_rst_n = 1'b1;
      @(negedge eth_clk);
      add_frame(2, 2, 0);
      add_frame(0, 2, 0);
      schedule();
      drain("post_reset", 100);

      repeat (5) @(negedge eth_clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/eth_tx_arb.md
Name: eth_tx_arb

Overview:
- Packet-granular round-robin arbiter that shares the single 64-bit Ethernet TX stream toward the MAC between several producers.
- Default producers: 0 = TLP encapsulator, 1 = NetTLP command-reply generator, 2 = PCIe-config-reply generator.
- Grant is locked from the first beat to the tlast beat of a frame, so frames never interleave.
- Enforces a programmable inter-frame idle gap. A watchdog aborts a granted frame that stalls mid-packet.

Parameters:
- N_REQ, 3: number of requesters (2..8).
- GAP_CYC, 1: idle cycles forced after each frame or abort (0..15).
- TIMEOUT_CYC, 1024: consecutive mid-frame cycles with granted s_tvalid low before abort. 0 disables the watchdog.

Ports:
- eth_clk  in  1  clock; all logic is on this clock.
- eth_rst_n  in  1  reset, asynchronous assert, active-low.
- s_tvalid  in  N_REQ  per-requester valid.
- s_tready  out  N_REQ  per-requester ready.
- s_tlast  in  N_REQ  per-requester end of frame.
- s_tkeep  in  N_REQ*8  per-requester byte enables; requester i uses bits [8i+7:8i].
- s_tdata  in  N_REQ*64  per-requester data; requester i uses bits [64i+63:64i].
- m_tvalid  out  1  to MAC.
- m_tready  in  1  from MAC.
- m_tlast  out  1  end of frame.
- m_tkeep  out  8  byte enables.
- m_tdata  out  64  data.
- m_tuser  out  1  1 = bad frame; MAC drops it.
- grant  out  N_REQ  one-hot current owner; 0 when no owner.
- abort_cnt  out  16  saturating count of watchdog aborts.

Behaviour:
- Beat transfer on the master side is m_tvalid && m_tready. Requester i transfers on s_tvalid[i] && s_tready[i].
- State machine: IDLE, PASS, ABORT, GAP.
- Reset values (asynchronous):
  - state = IDLE; grant = 0; rr_ptr = 0.
  - gap counter and watchdog counter = 0; abort_cnt = 0.
  - m_tvalid, m_tlast, m_tuser, m_tkeep, m_tdata = 0; s_tready = 0.
- Reset asserted mid-frame truncates the frame immediately with no tlast. This is accepted; the MAC discards runts.
- IDLE:
  - Arbitration searches for the first i with s_tvalid[i]=1, starting at rr_ptr and wrapping modulo N_REQ.
  - On a hit: register grant = one-hot(i) and go to PASS next cycle.
  - No beat is passed in IDLE. Requester-valid-to-first-transfer latency is 1 cycle.
- PASS:
  - Combinational pass-through: m_* = s_*[g] for g = granted index; m_tuser = 0.
  - s_tready[g] = m_tready; every other s_tready is 0.
  - On a transfer with s_tlast[g]=1: rr_ptr <= (g+1) mod N_REQ, grant <= 0.
  - After that tlast transfer: go to GAP if GAP_CYC>0, else IDLE.
- Back-to-back frames from the same requester: GAP_CYC=0 gives a 1-cycle arbitration bubble in IDLE. Other requesters pending at that point win by rotation.
- Watchdog (PASS only):
  - Counter increments on cycles with s_tvalid[g]=0, clears on any transfer, and is held at 0 before the first beat.
  - m_tready=0 never advances it; only source starvation does.
  - On reaching TIMEOUT_CYC: go to ABORT.
- ABORT:
  - Drive m_tvalid=1, m_tlast=1, m_tkeep=0, m_tdata=0, m_tuser=1.
  - All s_tready=0.
  - On m_tready: abort_cnt++ (saturates at 16'hFFFF), rr_ptr <= g+1, grant <= 0, go to GAP, or to IDLE if GAP_CYC=0.
  - The aborted requester's remaining beats are later arbitrated as a new frame. This is the requester's responsibility.
- GAP:
  - m_tvalid=0 and all s_tready=0 for exactly GAP_CYC cycles, then IDLE.
  - Requests arriving during GAP wait; they are not lost.
- Simultaneous events:
  - tlast transfer and a new request in the same cycle: the new request is seen in IDLE after the gap.
  - Watchdog expiry and a transfer in the same cycle: the transfer wins and the counter clears.
- Outputs in IDLE and GAP: m_tvalid=0, m_tlast=0, m_tuser=0.
- Formal or assertion checks:
  - grant is one-hot or zero.
  - s_tready is never set for a non-granted requester.
  - m_tvalid is never high in IDLE or GAP.

Test Plan:
- Single requester 0 sends a 5-beat frame, m_tready=1, GAP_CYC=1. Required: grant=001 one cycle after s_tvalid; 5 master beats identical to the source; 1 idle cycle; rr_ptr=1.
- All 3 requesters hold 2-beat frames continuously. Required: frame order 0,1,2,0,1,2; no interleaved beats; each gap exactly GAP_CYC cycles.
- m_tready toggles 1010… during a 4-beat frame from requester 2. Required: data stable while stalled; all 4 beats delivered; watchdog never fires.
- TIMEOUT_CYC=8; requester 1 sends 2 beats, then drops s_tvalid. Required: after 8 idle-source cycles, one beat with tlast=1, tkeep=00, tuser=1; abort_cnt=1; next grant goes to requester 2 if pending.
- Assert eth_rst_n low on beat 3 of a 6-beat frame. Required: m_tvalid=0 and grant=0 asynchronously. After release, arbitration restarts with requester 0 highest priority.
